// File: rtl/isi_ctrl_pkg.sv
// ============================================================================
// isi_ctrl_pkg : shared types, reset constants and helpers for isi_channel_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package isi_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        SWAP  = 2'd2
    } isi_state_t;

    // Identity pulse response: unit main cursor, no post-cursors, no shift.
    localparam int c_ident_tap0  = 1;
    localparam int c_ident_other = 0;
    localparam int c_ident_shift = 0;

    function automatic int tap_slice(input int i, input int mant_w);
        return i * mant_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/isi_tap_bank.sv
// ============================================================================
// isi_tap_bank : shadow/active tap register pair with atomic swap
// Rev 1.0
// ============================================================================
`default_nettype none

module isi_tap_bank
    import isi_ctrl_pkg::*;
#(
    parameter int TAPS    = 2,
    parameter int MANT_W  = 16,
    parameter int SHIFT_W = 8,
    parameter int ADDR_W  = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [MANT_W-1:0]        wr_mant,
    input  logic [SHIFT_W-1:0]       wr_shift,
    input  logic                     swap,
    output logic [TAPS*MANT_W-1:0]   tap_mant,
    output logic [SHIFT_W-1:0]       tap_shift
);

    logic [MANT_W-1:0]  r_shadow [TAPS];
    logic [MANT_W-1:0]  r_active [TAPS];
    logic [SHIFT_W-1:0] r_shadow_shift;
    logic [SHIFT_W-1:0] r_active_shift;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < TAPS; i++) begin
                r_shadow[i] <= (i == 0) ? MANT_W'(c_ident_tap0) : MANT_W'(c_ident_other);
                r_active[i] <= (i == 0) ? MANT_W'(c_ident_tap0) : MANT_W'(c_ident_other);
            end
            r_shadow_shift <= SHIFT_W'(c_ident_shift);
            r_active_shift <= SHIFT_W'(c_ident_shift);
        end else begin
            if (wr_en) begin
                r_shadow[wr_addr] <= wr_mant;
                // The shift travels with the main cursor write.
                if (wr_addr == '0) begin
                    r_shadow_shift <= wr_shift;
                end
            end
            if (swap) begin
                r_active       <= r_shadow;
                r_active_shift <= r_shadow_shift;
            end
        end
    end

    generate
        for (genvar i = 0; i < TAPS; i++) begin : g_pack
            assign tap_mant[tap_slice(i, MANT_W) +: MANT_W] = r_active[i];
        end
    endgenerate

    assign tap_shift = r_active_shift;

endmodule

`default_nettype wire

// File: rtl/isi_channel_ctrl.sv
// ============================================================================
// isi_channel_ctrl : symbol forwarding plus flush-then-swap tap reconfiguration
// Rev 1.0
// ============================================================================
`default_nettype none

module isi_channel_ctrl
    import isi_ctrl_pkg::*;
#(
    parameter int TAPS              = 2,
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SHIFT_W           = 8
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic signed [SIGNAL_RESOLUTION-1:0]    sym_in,
    input  logic                                   sym_in_valid,
    output logic                                   sym_in_ready,
    output logic signed [SIGNAL_RESOLUTION-1:0]    ch_sym,
    output logic                                   ch_sym_valid,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic                                   cfg_commit,
    input  logic [$clog2(TAPS > 1 ? TAPS : 2)-1:0] cfg_addr,
    input  logic signed [2*SIGNAL_RESOLUTION-1:0]  cfg_mant,
    input  logic [SHIFT_W-1:0]                     cfg_shift,
    output logic                                   cfg_err,
    output logic [TAPS*2*SIGNAL_RESOLUTION-1:0]    tap_mant,
    output logic [SHIFT_W-1:0]                     tap_shift,
    output logic                                   swapping
);

    localparam int ADDR_W = $clog2(TAPS > 1 ? TAPS : 2);
    localparam int CNT_W  = $clog2(TAPS > 1 ? TAPS : 2);
    localparam int MANT_W = 2 * SIGNAL_RESOLUTION;
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'((TAPS > 1) ? TAPS - 2 : 0);

    isi_state_t                     r_state;
    logic [CNT_W-1:0]               r_cnt;
    logic [SIGNAL_RESOLUTION-1:0]   r_ch_sym;
    logic                           r_ch_valid;
    logic                           r_cfg_err;

    logic w_run;
    logic w_sym_acc;
    logic w_cfg_wr;
    logic w_commit;
    logic w_addr_ok;

    assign w_run     = (r_state == RUN);
    assign w_sym_acc = sym_in_valid && w_run;
    assign w_cfg_wr  = cfg_valid && w_run && !cfg_commit;
    assign w_commit  = cfg_valid && w_run && cfg_commit;
    assign w_addr_ok = (int'(cfg_addr) < TAPS);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= RUN;
            r_cnt      <= '0;
            r_ch_sym   <= '0;
            r_ch_valid <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_wr && !w_addr_ok;
            case (r_state)
                RUN: begin
                    r_ch_valid <= w_sym_acc;
                    if (w_sym_acc) begin
                        r_ch_sym <= sym_in;
                    end
                    if (w_commit) begin
                        r_state <= (TAPS > 1) ? FLUSH : SWAP;
                        r_cnt   <= c_cnt_load;
                    end
                end
                FLUSH: begin
                    // Zero symbols drain the channel's ISI history before the swap.
                    r_ch_sym   <= '0;
                    r_ch_valid <= 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= SWAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                SWAP: begin
                    r_ch_valid <= 1'b0;
                    r_state    <= RUN;
                end
                default: begin
                    r_ch_valid <= 1'b0;
                    r_state    <= RUN;
                end
            endcase
        end
    end

    isi_tap_bank #(
        .TAPS    (TAPS),
        .MANT_W  (MANT_W),
        .SHIFT_W (SHIFT_W),
        .ADDR_W  (ADDR_W)
    ) u_tap_bank (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (w_cfg_wr && w_addr_ok),
        .wr_addr   (cfg_addr),
        .wr_mant   (cfg_mant),
        .wr_shift  (cfg_shift),
        .swap      (r_state == SWAP),
        .tap_mant  (tap_mant),
        .tap_shift (tap_shift)
    );

    assign sym_in_ready = w_run;
    assign cfg_ready    = w_run;
    assign swapping     = !w_run;
    assign ch_sym       = r_ch_sym;
    assign ch_sym_valid = r_ch_valid;
    assign cfg_err      = r_cfg_err;

endmodule

`default_nettype wire
